alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the integer ALU.
- Accepts a decoded instruction's register operands, applies one-source result bypass, and selects immediate/PC operands.
- Precomputes operand_a + operand_b and operand_a - operand_b.
- Registers everything into a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU sees registered operands, sum and difference after exactly one cycle.

Parameters:
- TAG_W, 32, width of the opaque sideband payload (operator, decoded fields, rd) carried alongside the operands unchanged.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  discard all buffered entries
- in_valid_i  in  1  upstream offers an instruction
- in_ready_o  out  1  stage can accept this cycle
- in_rs1_idx_i  in  5  source register 1 index
- in_rs2_idx_i  in  5  source register 2 index
- in_rs1_value_i  in  64  register-file value for rs1
- in_rs2_value_i  in  64  register-file value for rs2
- in_use_pc_i  in  1  operand_a = in_pc_i instead of rs1
- in_pc_i  in  64  instruction PC
- in_use_imm_i  in  1  operand_b = in_imm_i instead of rs2
- in_imm_i  in  64  sign-extended immediate
- in_is_32_i  in  1  word operation flag
- in_tag_i  in  TAG_W  sideband payload
- byp_valid_i  in  1  bypass value valid
- byp_rd_i  in  5  bypass destination register
- byp_value_i  in  64  bypass result
- out_valid_o  out  1  ALU-side entry valid
- out_ready_i  in  1  ALU side consumes entry
- out_operand_a_o  out  64  registered operand a
- out_operand_b_o  out  64  registered operand b
- out_sum_o  out  64  operand_a + operand_b (mod 2^64)
- out_difference_o  out  64  operand_a - operand_b (mod 2^64)
- out_is_32_o  out  1  registered word flag
- out_tag_o  out  TAG_W  registered payload

Behaviour:
- Accept = in_valid_i && in_ready_o. Drain = out_valid_o && out_ready_i.
- Forwarding, per source, evaluated combinationally at accept:
  - Use byp_value_i if byp_valid_i and byp_rd_i == idx and idx != 0.
  - Otherwise use the register-file value.
  - x0 is never forwarded.
- Operand select:
  - a = in_use_pc_i ? in_pc_i : fwd_rs1.
  - b = in_use_imm_i ? in_imm_i : fwd_rs2.
  - Forwarding does not apply to PC or immediate.
- Sum and difference are full 64-bit regardless of in_is_32_i; the ALU performs word sign-extension. No overflow flag; results wrap.
- Storage is a main register (drives outputs) plus a skid register, each with a valid bit. Entries are captured with already-forwarded values; later bypass activity never alters a stored entry.
- in_ready_o = !skid_valid && !rst_i. It depends on registered state only, with no combinational path from out_ready_i.
- Transitions (no flush):
  - Empty, accept → main.
  - Main only, accept and drain → main replaced.
  - Main only, accept without drain → skid.
  - Main only, drain without accept → empty.
  - Main+skid, drain → skid moves to main; skid empty; in_ready_o is 0 that cycle, so no accept.
  - Main+skid, no drain → hold; outputs stable.
- Ordering is strictly FIFO. Latency from accept to out_valid_o is 1 cycle when main is empty or draining.
- Outputs are held stable while out_valid_o && !out_ready_i.
- flush_i: both valids clear at the next edge. Any accept or drain in the flush cycle is discarded; flush has priority. Data registers need not be cleared.
- Reset: out_valid_o = 0, skid valid = 0, in_ready_o = 0 while rst_i is high and 1 the first cycle after. Data outputs are don't-care while out_valid_o = 0. Reset mid-operation drops all entries.
- No X may propagate into valid bits.

Test Plan:
- Reset, then accept rs1=5 (value 64'd10), rs2=6 (64'd3), out_ready_i=1 → next cycle out_valid_o=1, a=10, b=3, sum=13, difference=7.
- Bypass byp_valid_i=1, byp_rd_i=5, byp_value_i=64'hFFFF_FFFF_FFFF_FFFF with rs1 idx 5 → a=all ones; sum with b=1 is 0 (wrap); same with idx 0 and byp_rd_i=0 → register-file value used.
- in_use_pc_i=1, pc=64'h8000_0000, in_use_imm_i=1, imm=-4 → sum=64'h7FFF_FFFC, difference=64'h8000_0004.
- Hold out_ready_i=0 and offer 3 back-to-back instructions → first two accepted, in_ready_o=0 on the third; release → outputs appear in order 1,2,3, each held stable while stalled.
- Two entries buffered, assert flush_i together with in_valid_i → next cycle out_valid_o=0, in_ready_o=1, flushed-cycle input absent from the output.
- Assert rst_i while both entries are valid → out_valid_o=0 after the edge; in_ready_o=0 during reset, 1 after deassertion.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves register operands with a single-source result
// bypass, selects PC/immediate operands, precomputes a+b and a-b, and hands
// everything to the ALU through a two-entry (main + skid) registered buffer.
module alu_operand_stage #(
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0]       in_rs1_idx_i,
    input  logic [4:0]       in_rs2_idx_i,
    input  logic [63:0]      in_rs1_value_i,
    input  logic [63:0]      in_rs2_value_i,
    input  logic             in_use_pc_i,
    input  logic [63:0]      in_pc_i,
    input  logic             in_use_imm_i,
    input  logic [63:0]      in_imm_i,
    input  logic             in_is_32_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             byp_valid_i,
    input  logic [4:0]       byp_rd_i,
    input  logic [63:0]      byp_value_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      out_operand_a_o,
    output logic [63:0]      out_operand_b_o,
    output logic [63:0]      out_sum_o,
    output logic [63:0]      out_difference_o,
    output logic             out_is_32_o,
    output logic [TAG_W-1:0] out_tag_o
);

    typedef struct packed {
        logic [63:0]      operand_a;
        logic [63:0]      operand_b;
        logic [63:0]      sum;
        logic [63:0]      difference;
        logic             is_32;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t      main_r;
    entry_t      skid_r;
    entry_t      in_entry_s;
    logic        main_valid_r;
    logic        skid_valid_r;
    logic        main_valid_nx_s;
    logic        skid_valid_nx_s;
    logic        main_load_in_s;
    logic        main_load_skid_s;
    logic        skid_load_s;
    logic        accept_s;
    logic        drain_s;
    logic [63:0] fwd_rs1_s;
    logic [63:0] fwd_rs2_s;
    logic [63:0] op_a_s;
    logic [63:0] op_b_s;

    // Bypass wins over the register file only for a matching, non-zero index;
    // x0 always reads as the register-file value.
    function automatic logic [63:0] resolve_source(
        input logic [4:0]  idx,
        input logic [63:0] rf_value,
        input logic        bvalid,
        input logic [4:0]  brd,
        input logic [63:0] bvalue
    );
        logic [63:0] result;
        if (bvalid && (brd == idx) && (idx != 5'd0)) begin
            result = bvalue;
        end else begin
            result = rf_value;
        end
        return result;
    endfunction

    // Readiness depends on registered state (and reset) only, never on out_ready_i.
    assign in_ready_o = !skid_valid_r && !rst_i;
    assign accept_s   = in_valid_i && in_ready_o;
    assign drain_s    = main_valid_r && out_ready_i;

    // Build the incoming entry: forward, select operands, precompute sum/difference.
    always_comb begin
        fwd_rs1_s = resolve_source(in_rs1_idx_i, in_rs1_value_i, byp_valid_i, byp_rd_i, byp_value_i);
        fwd_rs2_s = resolve_source(in_rs2_idx_i, in_rs2_value_i, byp_valid_i, byp_rd_i, byp_value_i);
        if (in_use_pc_i) begin
            op_a_s = in_pc_i;
        end else begin
            op_a_s = fwd_rs1_s;
        end
        if (in_use_imm_i) begin
            op_b_s = in_imm_i;
        end else begin
            op_b_s = fwd_rs2_s;
        end
        in_entry_s.operand_a  = op_a_s;
        in_entry_s.operand_b  = op_b_s;
        in_entry_s.sum        = op_a_s + op_b_s;
        in_entry_s.difference = op_a_s - op_b_s;
        in_entry_s.is_32      = in_is_32_i;
        in_entry_s.tag        = in_tag_i;
    end

    // Occupancy next-state and data-load selection; flush discards everything.
    always_comb begin
        main_valid_nx_s  = main_valid_r;
        skid_valid_nx_s  = skid_valid_r;
        main_load_in_s   = 1'b0;
        main_load_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush_i) begin
            main_valid_nx_s = 1'b0;
            skid_valid_nx_s = 1'b0;
        end else begin
            case ({main_valid_r, skid_valid_r})
                2'b00: begin
                    if (accept_s) begin
                        main_valid_nx_s = 1'b1;
                        main_load_in_s  = 1'b1;
                    end else begin
                        main_valid_nx_s = 1'b0;
                    end
                end
                2'b10: begin
                    if (accept_s && drain_s) begin
                        main_load_in_s = 1'b1;
                    end else if (accept_s) begin
                        skid_valid_nx_s = 1'b1;
                        skid_load_s     = 1'b1;
                    end else if (drain_s) begin
                        main_valid_nx_s = 1'b0;
                    end else begin
                        main_valid_nx_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (drain_s) begin
                        main_load_skid_s = 1'b1;
                        skid_valid_nx_s  = 1'b0;
                    end else begin
                        skid_valid_nx_s = 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable; recover to empty.
                    main_valid_nx_s = 1'b0;
                    skid_valid_nx_s = 1'b0;
                end
            endcase
        end
    end

    // Valid bits: reset to a known empty state so no X reaches the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            main_valid_r <= main_valid_nx_s;
            skid_valid_r <= skid_valid_nx_s;
        end
    end

    // Payload registers: only written on a load, so stalled outputs stay stable.
    always_ff @(posedge clk_i) begin
        if (main_load_in_s) begin
            main_r <= in_entry_s;
        end else if (main_load_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
        if (skid_load_s) begin
            skid_r <= in_entry_s;
        end else begin
            skid_r <= skid_r;
        end
    end

    assign out_valid_o      = main_valid_r;
    assign out_operand_a_o  = main_r.operand_a;
    assign out_operand_b_o  = main_r.operand_b;
    assign out_sum_o        = main_r.sum;
    assign out_difference_o = main_r.difference;
    assign out_is_32_o      = main_r.is_32;
    assign out_tag_o        = main_r.tag;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: FIFO reference model plus directed literal checks
// and a randomized phase.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, in_valid_i, in_ready_o;
    logic [4:0]  in_rs1_idx_i, in_rs2_idx_i, byp_rd_i;
    logic [63:0] in_rs1_value_i, in_rs2_value_i, in_pc_i, in_imm_i, byp_value_i;
    logic        in_use_pc_i, in_use_imm_i, in_is_32_i, byp_valid_i;
    logic [31:0] in_tag_i, out_tag_o;
    logic        out_valid_o, out_ready_i, out_is_32_o;
    logic [63:0] out_operand_a_o, out_operand_b_o, out_sum_o, out_difference_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] s;
        logic [63:0] d;
        logic        w;
        logic [31:0] tag;
    } exp_t;

    exp_t q[$];

    alu_operand_stage #(.TAG_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_idx_i(in_rs1_idx_i), .in_rs2_idx_i(in_rs2_idx_i),
        .in_rs1_value_i(in_rs1_value_i), .in_rs2_value_i(in_rs2_value_i),
        .in_use_pc_i(in_use_pc_i), .in_pc_i(in_pc_i),
        .in_use_imm_i(in_use_imm_i), .in_imm_i(in_imm_i),
        .in_is_32_i(in_is_32_i), .in_tag_i(in_tag_i),
        .byp_valid_i(byp_valid_i), .byp_rd_i(byp_rd_i), .byp_value_i(byp_value_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_operand_a_o(out_operand_a_o), .out_operand_b_o(out_operand_b_o),
        .out_sum_o(out_sum_o), .out_difference_o(out_difference_o),
        .out_is_32_o(out_is_32_o), .out_tag_o(out_tag_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the ALU must see for the instruction currently offered.
    function automatic exp_t ref_entry();
        exp_t e;
        logic [63:0] r1, r2;
        r1 = (byp_valid_i && byp_rd_i == in_rs1_idx_i && in_rs1_idx_i != 0) ? byp_value_i : in_rs1_value_i;
        r2 = (byp_valid_i && byp_rd_i == in_rs2_idx_i && in_rs2_idx_i != 0) ? byp_value_i : in_rs2_value_i;
        e.a   = in_use_pc_i  ? in_pc_i  : r1;
        e.b   = in_use_imm_i ? in_imm_i : r2;
        e.s   = e.a + e.b;
        e.d   = e.a - e.b;
        e.w   = in_is_32_i;
        e.tag = in_tag_i;
        return e;
    endfunction

    // Model: a FIFO of capacity two; reset/flush empty it.
    always @(posedge clk) begin
        bit acc, drn;
        if (rst_i || flush_i) begin
            q.delete();
        end else begin
            acc = in_valid_i && (q.size() < 2);
            drn = (q.size() > 0) && out_ready_i;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_entry());
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", {63'd0, out_valid_o}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready_o}, {63'd0, (!rst_i && q.size() < 2)});
        if (q.size() != 0) begin
            chk("operand_a", out_operand_a_o, q[0].a);
            chk("operand_b", out_operand_b_o, q[0].b);
            chk("sum", out_sum_o, q[0].s);
            chk("difference", out_difference_o, q[0].d);
            chk("is_32", {63'd0, out_is_32_o}, {63'd0, q[0].w});
            chk("tag", {32'd0, out_tag_o}, {32'd0, q[0].tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [4:0] r1, input logic [63:0] v1,
                         input logic [4:0] r2, input logic [63:0] v2,
                         input logic [31:0] tag);
        in_valid_i     = 1'b1;
        in_rs1_idx_i   = r1;
        in_rs1_value_i = v1;
        in_rs2_idx_i   = r2;
        in_rs2_value_i = v2;
        in_tag_i       = tag;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        in_rs1_idx_i = 5'd0; in_rs2_idx_i = 5'd0; in_rs1_value_i = 64'd0; in_rs2_value_i = 64'd0;
        in_use_pc_i = 1'b0; in_pc_i = 64'd0; in_use_imm_i = 1'b0; in_imm_i = 64'd0;
        in_is_32_i = 1'b0; in_tag_i = 32'd0;
        byp_valid_i = 1'b0; byp_rd_i = 5'd0; byp_value_i = 64'd0;

        // Reset
        repeat (3) tick();
        chk("reset in_ready", {63'd0, in_ready_o}, 64'd0);
        chk("reset out_valid", {63'd0, out_valid_o}, 64'd0);
        rst_i = 1'b0;
        #1;
        chk("post-reset in_ready", {63'd0, in_ready_o}, 64'd1);

        // Basic add/sub
        offer(5'd5, 64'd10, 5'd6, 64'd3, 32'd100);
        tick();
        in_valid_i = 1'b0;
        chk("basic valid", {63'd0, out_valid_o}, 64'd1);
        chk("basic a", out_operand_a_o, 64'd10);
        chk("basic b", out_operand_b_o, 64'd3);
        chk("basic sum", out_sum_o, 64'd13);
        chk("basic diff", out_difference_o, 64'd7);

        // Bypass into rs1, wrap-around sum
        offer(5'd5, 64'd123, 5'd6, 64'd1, 32'd101);
        byp_valid_i = 1'b1; byp_rd_i = 5'd5; byp_value_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("byp a", out_operand_a_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("byp sum wrap", out_sum_o, 64'd0);
        chk("byp diff", out_difference_o, 64'hFFFF_FFFF_FFFF_FFFE);

        // x0 is never forwarded
        offer(5'd0, 64'd7, 5'd6, 64'd1, 32'd102);
        byp_rd_i = 5'd0;
        tick();
        chk("x0 a", out_operand_a_o, 64'd7);
        chk("x0 sum", out_sum_o, 64'd8);
        byp_valid_i = 1'b0;

        // PC + immediate
        offer(5'd5, 64'd1, 5'd6, 64'd2, 32'd103);
        in_use_pc_i = 1'b1; in_pc_i = 64'h8000_0000;
        in_use_imm_i = 1'b1; in_imm_i = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        chk("pc sum", out_sum_o, 64'h7FFF_FFFC);
        chk("pc diff", out_difference_o, 64'h8000_0004);
        in_use_pc_i = 1'b0; in_use_imm_i = 1'b0;
        in_valid_i = 1'b0;
        tick();

        // Stall with three back-to-back offers
        out_ready_i = 1'b0;
        offer(5'd1, 64'd11, 5'd2, 64'd1, 32'd1);
        tick();
        offer(5'd1, 64'd22, 5'd2, 64'd2, 32'd2);
        tick();
        offer(5'd1, 64'd33, 5'd2, 64'd3, 32'd3);
        chk("stall third ready", {63'd0, in_ready_o}, 64'd0);
        tick();
        chk("stall hold tag", {32'd0, out_tag_o}, 64'd1);
        chk("stall hold sum", out_sum_o, 64'd12);
        out_ready_i = 1'b1;
        tick();
        chk("order tag2", {32'd0, out_tag_o}, 64'd2);
        tick();
        in_valid_i = 1'b0;
        chk("order tag3", {32'd0, out_tag_o}, 64'd3);
        tick();

        // Flush with two buffered and a simultaneous offer
        out_ready_i = 1'b0;
        offer(5'd1, 64'd1, 5'd2, 64'd1, 32'd10);
        tick();
        offer(5'd1, 64'd2, 5'd2, 64'd1, 32'd11);
        tick();
        offer(5'd1, 64'd3, 5'd2, 64'd1, 32'd12);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("flush in_ready", {63'd0, in_ready_o}, 64'd1);
        out_ready_i = 1'b1;
        tick();
        chk("flush absent", {63'd0, out_valid_o}, 64'd0);

        // Reset while full
        out_ready_i = 1'b0;
        offer(5'd1, 64'd4, 5'd2, 64'd1, 32'd20);
        tick();
        offer(5'd1, 64'd5, 5'd2, 64'd1, 32'd21);
        tick();
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk("rst full out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst full in_ready", {63'd0, in_ready_o}, 64'd0);
        rst_i = 1'b0;
        #1;
        chk("rst release in_ready", {63'd0, in_ready_o}, 64'd1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid_i     = ($urandom_range(0, 3) != 0);
            out_ready_i    = ($urandom_range(0, 2) != 0);
            in_rs1_idx_i   = 5'($urandom_range(0, 3));
            in_rs2_idx_i   = 5'($urandom_range(0, 3));
            in_rs1_value_i = {$urandom(), $urandom()};
            in_rs2_value_i = {$urandom(), $urandom()};
            in_use_pc_i    = ($urandom_range(0, 4) == 0);
            in_pc_i        = {$urandom(), $urandom()};
            in_use_imm_i   = ($urandom_range(0, 3) == 0);
            in_imm_i       = {$urandom(), $urandom()};
            in_is_32_i     = 1'($urandom_range(0, 1));
            in_tag_i       = $urandom();
            byp_valid_i    = 1'($urandom_range(0, 1));
            byp_rd_i       = 5'($urandom_range(0, 3));
            byp_value_i    = {$urandom(), $urandom()};
            flush_i        = ($urandom_range(0, 24) == 0);
            rst_i          = ($urandom_range(0, 59) == 0);
            tick();
        end
        in_valid_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0; out_ready_i = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
